// File: rtl/mod_step_counter_pkg.sv
// Shared types and the configuration legality check for the modular step counter.
package mod_step_counter_pkg;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_COUNT,
        OP_LOAD,
        OP_CFG
    } lane_op_e;

    // A modulus must leave room for at least two states and fit the count width.
    function automatic logic cfg_valid(
        input int unsigned mod_v,
        input int unsigned step_v,
        input int unsigned ch_v,
        input int unsigned width,
        input int unsigned nch
    );
        return (mod_v >= 32'd2) && (mod_v <= (32'd1 << width)) &&
               (step_v < mod_v) && (ch_v < nch);
    endfunction

endpackage

// File: rtl/mod_step_lane.sv
// One counter channel: step, modulus and count registers with the up/down/wrap datapath.
module mod_step_lane
    import mod_step_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned DEF_STEP = 3,
    parameter int unsigned DEF_MOD  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel_cfg,
    input  logic             cfg_ok,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic [WIDTH:0]   cfg_mod,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             ld_rej
);

    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH:0]   mod_q, mod_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    lane_op_e         op;
    logic [WIDTH:0]   sum, sum_wrapped, down_wrapped;

    always_comb begin
        step_d       = step_q;
        mod_d        = mod_q;
        cnt_d        = cnt_q;
        wrap_d       = 1'b0;
        ld_rej       = 1'b0;
        sum          = {1'b0, cnt_q} + {1'b0, step_q};
        sum_wrapped  = sum - mod_q;
        down_wrapped = {1'b0, cnt_q} + mod_q - {1'b0, step_q};

        // A config write aimed at this lane blocks ld/en even when it is rejected.
        if (sel_cfg)      op = OP_CFG;
        else if (ld)      op = OP_LOAD;
        else if (en)      op = OP_COUNT;
        else              op = OP_HOLD;

        case (op)
            OP_CFG: begin
                if (cfg_ok) begin
                    step_d = cfg_step;
                    mod_d  = cfg_mod;
                    cnt_d  = '0;
                end
            end
            OP_LOAD: begin
                if ({1'b0, ld_val} < mod_q) cnt_d  = ld_val;
                else                        ld_rej = 1'b1;
            end
            OP_COUNT: begin
                if (!dir) begin
                    if (sum >= mod_q) begin
                        cnt_d  = sum_wrapped[WIDTH-1:0];
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = sum[WIDTH-1:0];
                    end
                end else if (cnt_q >= step_q) begin
                    cnt_d = cnt_q - step_q;
                end else begin
                    cnt_d  = down_wrapped[WIDTH-1:0];
                    wrap_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q <= WIDTH'(DEF_STEP);
            mod_q  <= (WIDTH+1)'(DEF_MOD);
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            step_q <= step_d;
            mod_q  <= mod_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/mod_step_counter.sv
// Multi-channel modular step counter: validates config writes once and fans out to NCH lanes.
module mod_step_counter
    import mod_step_counter_pkg::*;
#(
    parameter  int unsigned WIDTH    = 3,
    parameter  int unsigned NCH      = 2,
    parameter  int unsigned DEF_STEP = 3,
    parameter  int unsigned DEF_MOD  = 7,
    localparam int unsigned CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       dir,
    input  logic [NCH-1:0]       ld,
    input  logic [NCH*WIDTH-1:0] ld_val,
    input  logic                 cfg_we,
    input  logic [CHW-1:0]       cfg_ch,
    input  logic [WIDTH-1:0]     cfg_step,
    input  logic [WIDTH:0]       cfg_mod,
    output logic [NCH*WIDTH-1:0] q,
    output logic [NCH-1:0]       wrap,
    output logic                 err
);

    logic           cfg_ok;
    logic [NCH-1:0] sel_cfg;
    logic [NCH-1:0] ld_rej;
    logic           err_q, err_d;

    assign cfg_ok = cfg_valid(32'(cfg_mod), 32'(cfg_step), 32'(cfg_ch), WIDTH, NCH);

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        assign sel_cfg[i] = cfg_we && (32'(cfg_ch) == i);

        mod_step_lane #(
            .WIDTH    (WIDTH),
            .DEF_STEP (DEF_STEP),
            .DEF_MOD  (DEF_MOD)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .sel_cfg  (sel_cfg[i]),
            .cfg_ok   (cfg_ok),
            .cfg_step (cfg_step),
            .cfg_mod  (cfg_mod),
            .ld       (ld[i]),
            .ld_val   (ld_val[i*WIDTH +: WIDTH]),
            .en       (en[i]),
            .dir      (dir[i]),
            .q        (q[i*WIDTH +: WIDTH]),
            .wrap     (wrap[i]),
            .ld_rej   (ld_rej[i])
        );
    end

    assign err_d = (cfg_we && !cfg_ok) || (|ld_rej);

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;

endmodule

// File: tb/tb_mod_step_counter.sv
// Directed and randomized checks of mod_step_counter against an arithmetic reference model.
module tb_mod_step_counter;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned NCH   = 2;
    localparam int unsigned CHW   = 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       en, dir, ld;
    logic [NCH*WIDTH-1:0] ld_val;
    logic                 cfg_we;
    logic [CHW-1:0]       cfg_ch;
    logic [WIDTH-1:0]     cfg_step;
    logic [WIDTH:0]       cfg_mod;
    logic [NCH*WIDTH-1:0] q;
    logic [NCH-1:0]       wrap;
    logic                 err;

    int checks   = 0;
    int failures = 0;

    int unsigned mq    [NCH];
    int unsigned mstep [NCH];
    int unsigned mmod  [NCH];
    bit          mwrap [NCH];
    bit          merr;

    always #5 clk = ~clk;

    mod_step_counter #(
        .WIDTH    (WIDTH),
        .NCH      (NCH),
        .DEF_STEP (3),
        .DEF_MOD  (7)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .ld       (ld),
        .ld_val   (ld_val),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_step (cfg_step),
        .cfg_mod  (cfg_mod),
        .q        (q),
        .wrap     (wrap),
        .err      (err)
    );

    task automatic idle_inputs();
        rst_n    = 1'b1;
        en       = '0;
        dir      = '0;
        ld       = '0;
        ld_val   = '0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_step = '0;
        cfg_mod  = '0;
    endtask

    // Reference model: modular arithmetic on plain integers.
    task automatic model_edge();
        bit          ok;
        int unsigned lv, old;
        if (!rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                mq[ch] = 0; mstep[ch] = 3; mmod[ch] = 7; mwrap[ch] = 0;
            end
            merr = 0;
            return;
        end
        ok = (cfg_mod >= 2) && (cfg_mod <= (1 << WIDTH)) && (cfg_step < cfg_mod) &&
             (cfg_ch < NCH);
        merr = cfg_we && !ok;
        for (int ch = 0; ch < NCH; ch++) begin
            mwrap[ch] = 0;
            lv  = ld_val[ch*WIDTH +: WIDTH];
            old = mq[ch];
            if (cfg_we && cfg_ch == ch) begin
                if (ok) begin
                    mstep[ch] = cfg_step; mmod[ch] = cfg_mod; mq[ch] = 0;
                end
            end else if (ld[ch]) begin
                if (lv < mmod[ch]) mq[ch] = lv;
                else               merr = 1;
            end else if (en[ch]) begin
                if (!dir[ch]) begin
                    mq[ch]    = (old + mstep[ch]) % mmod[ch];
                    mwrap[ch] = (old + mstep[ch]) >= mmod[ch];
                end else begin
                    mq[ch]    = (old + mmod[ch] - mstep[ch]) % mmod[ch];
                    mwrap[ch] = old < mstep[ch];
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [WIDTH-1:0] act_q, exp_q;
        for (int ch = 0; ch < NCH; ch++) begin
            act_q = q[ch*WIDTH +: WIDTH];
            exp_q = WIDTH'(mq[ch]);
            checks++;
            assert (act_q === exp_q) else begin
                failures++;
                $error("FAIL %s q%0d observed=%0d expected=%0d", tag, ch, act_q, exp_q);
            end
            checks++;
            assert (wrap[ch] === mwrap[ch]) else begin
                failures++;
                $error("FAIL %s wrap%0d observed=%0b expected=%0b", tag, ch, wrap[ch], mwrap[ch]);
            end
        end
        checks++;
        assert (err === merr) else begin
            failures++;
            $error("FAIL %s err observed=%0b expected=%0b", tag, err, merr);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    // Fixed expectations taken directly from the worked examples.
    task automatic expect_lane(input string tag, input int ch, input int unsigned eq, input bit ew);
        logic [WIDTH-1:0] act_q, exp_q;
        act_q = q[ch*WIDTH +: WIDTH];
        exp_q = WIDTH'(eq);
        checks++;
        assert (act_q === exp_q && wrap[ch] === ew) else begin
            failures++;
            $error("FAIL %s q%0d/wrap observed=%0d/%0b expected=%0d/%0b",
                   tag, ch, act_q, wrap[ch], exp_q, ew);
        end
    endtask

    task automatic expect_err(input string tag, input bit ee);
        checks++;
        assert (err === ee) else begin
            failures++;
            $error("FAIL %s err observed=%0b expected=%0b", tag, err, ee);
        end
    endtask

    int unsigned up_q [7]   = '{3, 6, 2, 5, 1, 4, 0};
    bit          up_w [7]   = '{0, 0, 1, 0, 1, 0, 1};
    int unsigned dn_q [7]   = '{4, 1, 5, 2, 6, 3, 0};
    bit          dn_w [7]   = '{1, 0, 1, 0, 1, 0, 0};
    int unsigned c3_q [4]   = '{5, 2, 7, 4};
    bit          c3_w [4]   = '{0, 1, 0, 1};
    int unsigned bad_m [3]  = '{1, 7, 9};
    int unsigned bad_s [3]  = '{0, 7, 2};

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick("reset");
        tick("reset_hold");
        expect_lane("reset_q0", 0, 0, 0);
        expect_lane("reset_q1", 1, 0, 0);
        expect_err("reset_err", 0);
        rst_n = 1'b1;

        en = 2'b01;
        for (int k = 0; k < 7; k++) begin
            tick("up_ch0");
            expect_lane("up_ch0_fixed", 0, up_q[k], up_w[k]);
        end

        en = 2'b10; dir = 2'b10;
        for (int k = 0; k < 7; k++) begin
            tick("down_ch1");
            expect_lane("down_ch1_fixed", 1, dn_q[k], dn_w[k]);
        end

        idle_inputs();
        cfg_we = 1'b1; cfg_ch = 1'b1; cfg_step = 3'd5; cfg_mod = 4'd8;
        tick("cfg_ch1");
        expect_lane("cfg_ch1_zero", 1, 0, 0);
        expect_err("cfg_ch1_err", 0);
        idle_inputs();
        en = 2'b10;
        for (int k = 0; k < 4; k++) begin
            tick("up_mod8");
            expect_lane("up_mod8_fixed", 1, c3_q[k], c3_w[k]);
        end

        idle_inputs();
        en = 2'b01;
        tick("pre_reject");
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            cfg_we = 1'b1; cfg_ch = 1'b0;
            cfg_step = WIDTH'(bad_s[k]); cfg_mod = (WIDTH+1)'(bad_m[k]);
            tick("cfg_reject");
            expect_err("cfg_reject_err", 1);
            expect_lane("cfg_reject_hold", 0, 3, 0);
        end
        idle_inputs();
        en = 2'b01;
        tick("step_kept");
        expect_lane("step_kept_fixed", 0, 6, 0);

        idle_inputs();
        ld = 2'b01; en = 2'b01; ld_val = 6'd5;
        tick("load_wins");
        expect_lane("load_wins_fixed", 0, 5, 0);
        ld_val = 6'd7;
        tick("load_reject");
        expect_err("load_reject_err", 1);
        expect_lane("load_reject_hold", 0, 5, 0);

        idle_inputs();
        en = 2'b11;
        tick("midcount");
        tick("midcount");
        rst_n = 1'b0; cfg_we = 1'b1; cfg_ch = 1'b0; cfg_step = 3'd1; cfg_mod = 4'd5;
        tick("reset_over_cfg");
        expect_lane("reset_over_cfg_q0", 0, 0, 0);
        expect_err("reset_over_cfg_err", 0);
        idle_inputs();
        en = 2'b01;
        tick("after_reset");
        expect_lane("after_reset_def_step", 0, 3, 0);

        for (int n = 0; n < 500; n++) begin
            rst_n    = ($urandom_range(0, 59) != 0);
            en       = NCH'($urandom);
            dir      = NCH'($urandom);
            ld       = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            ld_val   = (NCH*WIDTH)'($urandom);
            cfg_we   = ($urandom_range(0, 5) == 0);
            cfg_ch   = CHW'($urandom);
            cfg_step = WIDTH'($urandom);
            cfg_mod  = (WIDTH+1)'($urandom);
            tick("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
